ewb_cam: RTL and testbench

EWB_CAM -- requirements
Module: ewb_cam

---
 rtl/rv32i_types.sv | 14 +
 rtl/ewb_cam_match.sv | 34 +++
 rtl/ewb_cam.sv | 151 +++++++++++++++
 tb/tb_ewb_cam.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared constants and entry layout for the eviction write buffer (ewb_cam).
package rv32i_types;

  localparam int unsigned EwbWidth     = 256;
  localparam int unsigned EwbDepthLog2 = 3;
  localparam int unsigned EwbOffsetW   = 5;

  typedef struct packed {
    logic                      valid;
    logic [31-EwbOffsetW:0]    tag;
    logic [EwbWidth-1:0]       data;
  } ewb_entry_t;

endpackage

// File: rtl/ewb_cam_match.sv
// Tag compare across all entries; on several matches picks the one closest to newest_i
// (the most recently allocated slot).
module ewb_cam_match #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TAG_W      = 27
) (
  input  logic [2**DEPTH_LOG2-1:0]             valid_i,
  input  logic [2**DEPTH_LOG2-1:0][TAG_W-1:0]  tags_i,
  input  logic [TAG_W-1:0]                     key_i,
  input  logic [DEPTH_LOG2-1:0]                newest_i,
  output logic                                 hit_o,
  output logic [DEPTH_LOG2-1:0]                idx_o
);

  localparam int Depth = 2**DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  idx_t idx;

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    idx   = '0;
    for (int k = Depth - 1; k >= 0; k--) begin
      idx = newest_i - idx_t'(k);
      if (valid_i[idx] && (tags_i[idx] == key_i)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/ewb_cam.sv
// Eviction write buffer: circular FIFO of dirty lines with a registered CAM lookup.
// Define EWB_CAM_COALESCE_EN to merge writes into a matching non-head entry.
module ewb_cam
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH      = EwbWidth,
  parameter int unsigned DEPTH_LOG2 = EwbDepthLog2,
  parameter int unsigned OFFSET_W   = EwbOffsetW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  input  logic [31:0]           wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [31:0]           rd_addr_o,
  output logic [WIDTH-1:0]      rd_data_o,
  input  logic                  rd_yumi_i,
  input  logic                  lk_valid_i,
  input  logic [31:0]           lk_addr_i,
  output logic                  lk_hit_o,
  output logic [WIDTH-1:0]      lk_data_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned Depth = 2**DEPTH_LOG2;
  localparam int unsigned TagW  = 32 - OFFSET_W;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FullCnt = cnt_t'(Depth);

  ptr_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, newest;
  cnt_t             count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic             lk_hit_q, lk_hit_d;
  logic [WIDTH-1:0] lk_data_q, lk_data_d;

  logic [31:0]      addr_q [Depth];
  logic [WIDTH-1:0] data_q [Depth];

  logic [Depth-1:0][TagW-1:0] tags;
  logic             lk_hit;
  ptr_t             lk_idx;
  logic             co_hit;
  ptr_t             co_idx;
  logic             wr_fire, alloc, co_fire, rd_fire;
  logic             unused_lk_offset;

  assign unused_lk_offset = ^lk_addr_i[OFFSET_W-1:0];
  assign newest           = wr_ptr_q - ptr_t'(1);

  always_comb begin
    for (int i = 0; i < Depth; i++) tags[i] = addr_q[i][31:OFFSET_W];
  end

  ewb_cam_match #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TAG_W      (TagW)
  ) u_lk_match (
    .valid_i  (valid_q),
    .tags_i   (tags),
    .key_i    (lk_addr_i[31:OFFSET_W]),
    .newest_i (newest),
    .hit_o    (lk_hit),
    .idx_o    (lk_idx)
  );

`ifdef EWB_CAM_COALESCE_EN
  // The head may already be streaming out to memory, so it never absorbs a write.
  logic [Depth-1:0] co_valid;
  always_comb begin
    co_valid           = valid_q;
    co_valid[rd_ptr_q] = 1'b0;
  end

  ewb_cam_match #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TAG_W      (TagW)
  ) u_co_match (
    .valid_i  (co_valid),
    .tags_i   (tags),
    .key_i    (wr_addr_i[31:OFFSET_W]),
    .newest_i (newest),
    .hit_o    (co_hit),
    .idx_o    (co_idx)
  );
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;
`endif

  always_comb begin
    rd_valid_o = (count_q != '0);
    wr_ready_o = (count_q != FullCnt) || co_hit;
    wr_fire    = wr_valid_i && wr_ready_o;
    alloc      = wr_fire && !co_hit;
    co_fire    = wr_fire && co_hit;
    rd_fire    = rd_valid_o && rd_yumi_i;
    rd_addr_o  = addr_q[rd_ptr_q];
    rd_data_o  = data_q[rd_ptr_q];
    count_o    = count_q;
    lk_hit_o   = lk_hit_q;
    lk_data_o  = lk_data_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ptr_t'(alloc);
    rd_ptr_d  = rd_ptr_q + ptr_t'(rd_fire);
    count_d   = count_q + cnt_t'(alloc) - cnt_t'(rd_fire);
    valid_d   = valid_q;
    if (rd_fire) valid_d[rd_ptr_q] = 1'b0;
    if (alloc)   valid_d[wr_ptr_q] = 1'b1;
    lk_hit_d  = lk_hit_q;
    lk_data_d = lk_data_q;
    if (lk_valid_i) begin
      lk_hit_d  = lk_hit;
      lk_data_d = data_q[lk_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      lk_hit_q  <= 1'b0;
      lk_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      lk_hit_q  <= lk_hit_d;
      lk_data_q <= lk_data_d;
    end
  end

  // Line storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wr_ptr_q] <= wr_addr_i;
      data_q[wr_ptr_q] <= wr_data_i;
    end
    if (co_fire) data_q[co_idx] <= wr_data_i;
  end

endmodule

// File: tb/tb_ewb_cam.sv
// Directed and randomized bench for ewb_cam against a queue-based model of the buffer.
module tb_ewb_cam;

  logic         clk, rst;
  logic         wr_valid_i, wr_ready_o, rd_valid_o, rd_yumi_i, lk_valid_i, lk_hit_o;
  logic [31:0]  wr_addr_i, rd_addr_o, lk_addr_i;
  logic [255:0] wr_data_i, rd_data_o, lk_data_o;
  logic [3:0]   count_o;

  ewb_cam u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (wr_valid_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .rd_valid_o (rd_valid_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_yumi_i  (rd_yumi_i),
    .lk_valid_i (lk_valid_i),
    .lk_addr_i  (lk_addr_i),
    .lk_hit_o   (lk_hit_o),
    .lk_data_o  (lk_data_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: oldest line at index 0.
  logic [31:0]  q_addr[$];
  logic [255:0] q_data[$];
  logic         lk_hit_m;
  logic [255:0] lk_data_m;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] tg(input logic [31:0] a);
    return a[31:5];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, check pre-edge outputs at negedge, advance model, check after edge.
  task automatic cyc(input logic wv, input logic [31:0] wa, input logic [255:0] wd,
                     input logic y, input logic lv, input logic [31:0] la);
    int   n, co;
    logic ready, found;
    wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd;
    rd_yumi_i  = y;  lk_valid_i = lv; lk_addr_i = la;
    @(negedge clk);
    n  = q_addr.size();
    co = -1;
`ifdef EWB_CAM_COALESCE_EN
    for (int i = n - 1; i >= 1; i--) if (co < 0 && tg(q_addr[i]) == tg(wa)) co = i;
`endif
    ready = (n < 8) || (co >= 0);
    chk("rd_valid", rd_valid_o, n != 0);
    chk("wr_ready", wr_ready_o, ready);
    chk("count_pre", count_o, n);
    if (n != 0) begin
      chk("rd_addr", rd_addr_o, q_addr[0]);
      chk("rd_data", rd_data_o, q_data[0]);
    end
    if (lv) begin
      lk_hit_m = 1'b0;
      found    = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && tg(q_addr[i]) == tg(la)) begin
          found = 1'b1; lk_hit_m = 1'b1; lk_data_m = q_data[i];
        end
      end
    end
    if (wv && ready && co >= 0) q_data[co] = wd;
    if (y && n > 0) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (wv && ready && co < 0) begin
      q_addr.push_back(wa);
      q_data.push_back(wd);
    end
    @(posedge clk);
    #1;
    chk("lk_hit", lk_hit_o, lk_hit_m);
    if (lk_hit_m) chk("lk_data", lk_data_o, lk_data_m);
    chk("count_post", count_o, q_addr.size());
  endtask

  task automatic drain_all();
    for (int k = 0; k < 16 && q_addr.size() > 0; k++) cyc(0, 0, 0, 1, 0, 0);
    chk("drained", count_o, 0);
  endtask

  logic [255:0] da, db, dc, dd, de;

  initial begin
    rst = 1'b1;
    wr_valid_i = 0; wr_addr_i = 0; wr_data_i = 0; rd_yumi_i = 0; lk_valid_i = 0; lk_addr_i = 0;
    lk_hit_m = 1'b0; lk_data_m = '0;
    da = rnd256(); db = rnd256(); dc = rnd256(); dd = rnd256(); de = rnd256();
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_lk_hit", lk_hit_o, 0);
    chk("rst_lk_data", lk_data_o, 0);
    chk("rst_wr_ready", wr_ready_o, 1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Basic lookup hit with offset bits ignored, then a miss.
    cyc(1, 32'h1000, da, 0, 0, 0);
    cyc(1, 32'h2000, db, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h101C);
    chk("lk_hit_101c", lk_hit_o, 1);
    chk("lk_data_101c", lk_data_o, da);
    cyc(0, 0, 0, 0, 1, 32'h3000);
    chk("lk_miss_3000", lk_hit_o, 0);
    drain_all();

    // Duplicate write with a different line in front of it at the head.
    cyc(1, 32'h0800, dd, 0, 0, 0);
    cyc(1, 32'h1000, da, 0, 0, 0);
    cyc(1, 32'h2000, db, 0, 0, 0);
    cyc(1, 32'h1000, dc, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1000);
    chk("dup_lk_data", lk_data_o, dc);
`ifdef EWB_CAM_COALESCE_EN
    chk("dup_count", count_o, 3);
`else
    chk("dup_count", count_o, 4);
`endif
    cyc(0, 0, 0, 1, 0, 0);
    chk("head_addr_1000", rd_addr_o, 32'h1000);
`ifdef EWB_CAM_COALESCE_EN
    chk("head_data_merged", rd_data_o, dc);
    cyc(1, 32'h1000, de, 0, 0, 0);
    chk("head_rewrite_allocs", count_o, 3);
`else
    chk("head_data_orig", rd_data_o, da);
    cyc(1, 32'h1000, de, 0, 0, 0);
    chk("head_rewrite_allocs", count_o, 4);
`endif
    drain_all();

    // Fill to full, then a write refused while the head drains.
    for (int i = 0; i < 8; i++) cyc(1, 32'h10000 + i * 32'h100, rnd256(), 0, 0, 0);
    chk("full_count", count_o, 8);
    chk("full_ready", wr_ready_o, 0);
    chk("full_head", rd_addr_o, 32'h10000);
    cyc(1, 32'h9000, rnd256(), 1, 0, 0);
    chk("full_wr_yumi_count", count_o, 7);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h10500);
    chk("pre_rst_hit", lk_hit_o, 1);

    // Asynchronous reset with 5 entries and a lookup being presented.
    wr_valid_i = 1'b0; rd_yumi_i = 1'b0; lk_valid_i = 1'b1; lk_addr_i = 32'h10600;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_rd_valid", rd_valid_o, 0);
    chk("mid_rst_lk_hit", lk_hit_o, 0);
    chk("mid_rst_lk_data", lk_data_o, 0);
    q_addr.delete(); q_data.delete(); lk_hit_m = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    lk_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", wr_ready_o, 1);
    chk("post_rst_rd_valid", rd_valid_o, 0);
    @(posedge clk);
    #1;

    // Random traffic over a small tag pool: a filling phase then a draining phase.
    for (int i = 0; i < 400; i++) begin
      logic wv, y, lv;
      wv = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      y  = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      lv = $urandom_range(0, 1) == 1;
      cyc(wv, 32'h1000 * $urandom_range(1, 6) + $urandom_range(0, 31), rnd256(), y, lv,
          32'h1000 * $urandom_range(1, 7) + $urandom_range(0, 31));
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
